// File: rtl/song_sequencer.sv
// Note-ROM tune player: fetches {note, beats} entries from one song slot, holds each note for
// beats*TICKS_PER_BEAT cycles, optionally followed by a rest gap, and pulses oDone at song end.
module song_sequencer #(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned SLOT_BITS      = 5,
  parameter int unsigned TICKS_PER_BEAT = 12500000,
  parameter int unsigned GAP_CYCLES     = 1250000
) (
  input  logic              iClk,
  input  logic              iReset_n,
  input  logic              iStart,
  input  logic              iStop,
  input  logic [1:0]        iSongSel,
  input  logic [11:0]       iRomData,
  output logic [ADDR_W-1:0] oRomAddr,
  output logic [7:0]        oNote,
  output logic              oPlaying,
  output logic              oDone
);

  localparam int unsigned TickW = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
  localparam int unsigned GapW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [7:0]  RestCode = 8'd99;

  typedef enum logic [2:0] {StIdle, StFetch, StLoad, StPlay, StGap, StDone} state_e;

  state_e                state_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [SLOT_BITS-1:0]  offset_q;
  logic [7:0]            note_q;
  logic [7:0]            out_note_q;
  logic [3:0]            beat_q;
  logic [TickW-1:0]      tick_q;
  logic [GapW-1:0]       gap_q;
  logic                  playing_q;
  logic                  done_q;

  logic tick_wrap, note_end, gap_end, advance, last_entry;

  always_comb begin
    tick_wrap  = (tick_q == TickW'(TICKS_PER_BEAT - 1));
    note_end   = (state_q == StPlay) && tick_wrap && (beat_q == 4'd1);
    gap_end    = (state_q == StGap) && (gap_q == GapW'(GAP_CYCLES - 1));
    advance    = (GAP_CYCLES == 0) ? note_end : gap_end;
    last_entry = &offset_q;
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      offset_q   <= '0;
      note_q     <= '0;
      out_note_q <= '0;
      beat_q     <= '0;
      tick_q     <= '0;
      gap_q      <= '0;
      playing_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (iStop && (state_q != StIdle)) begin
        state_q    <= StIdle;
        out_note_q <= '0;
        playing_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (iStart && !iStop) begin
              addr_q    <= ADDR_W'(iSongSel) << SLOT_BITS;
              offset_q  <= '0;
              playing_q <= 1'b1;
              state_q   <= StFetch;
            end
          end
          StFetch: state_q <= StLoad;
          StLoad: begin
            if (iRomData[3:0] == 4'd0) begin
              state_q    <= StDone;
              out_note_q <= '0;
              playing_q  <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              note_q     <= iRomData[11:4];
              out_note_q <= iRomData[11:4];
              beat_q     <= iRomData[3:0];
              tick_q     <= '0;
              state_q    <= StPlay;
            end
          end
          StPlay: begin
            if (tick_wrap) begin
              tick_q <= '0;
              beat_q <= beat_q - 4'd1;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
            if (note_end && (GAP_CYCLES != 0)) begin
              state_q    <= StGap;
              out_note_q <= RestCode;
              gap_q      <= '0;
            end
          end
          StGap:  gap_q   <= gap_q + 1'b1;
          StDone: state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
        // The last slot entry ends the song implicitly so the next slot is never read.
        if (advance) begin
          if (last_entry) begin
            state_q    <= StDone;
            out_note_q <= '0;
            playing_q  <= 1'b0;
            done_q     <= 1'b1;
          end else begin
            addr_q     <= addr_q + 1'b1;
            offset_q   <= offset_q + 1'b1;
            out_note_q <= note_q;
            state_q    <= StFetch;
          end
        end
      end
    end
  end

  assign oRomAddr = addr_q;
  assign oNote    = out_note_q;
  assign oPlaying = playing_q;
  assign oDone    = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: a per-cycle scoreboard of {note, playing, done, addr}
// built from a small playback model and checked against a gap DUT and a zero-gap DUT.
module tb_song_sequencer;

  localparam int unsigned Tpb     = 4;
  localparam int unsigned Gap     = 2;
  localparam int unsigned SlotLen = 4;

  typedef struct packed {
    logic [7:0] note;
    logic       playing;
    logic       done;
    logic [7:0] addr;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, stop, start0, stop0;
  logic [1:0] sel;
  logic [11:0] rom [256];
  logic [11:0] rom0 [256];
  logic [11:0] rom_q, rom0_q;
  logic [7:0] addr, addr0, note, note0;
  logic       playing, playing0, done, done0;

  always_ff @(posedge clk) begin
    rom_q  <= rom[addr];
    rom0_q <= rom0[addr0];
  end

  song_sequencer #(
    .ADDR_W(8), .SLOT_BITS(2), .TICKS_PER_BEAT(Tpb), .GAP_CYCLES(Gap)
  ) u_dut (
    .iClk(clk), .iReset_n(rst_n), .iStart(start), .iStop(stop), .iSongSel(sel),
    .iRomData(rom_q), .oRomAddr(addr), .oNote(note), .oPlaying(playing), .oDone(done)
  );

  song_sequencer #(
    .ADDR_W(8), .SLOT_BITS(2), .TICKS_PER_BEAT(Tpb), .GAP_CYCLES(0)
  ) u_dut_zg (
    .iClk(clk), .iReset_n(rst_n), .iStart(start0), .iStop(stop0), .iSongSel(sel),
    .iRomData(rom0_q), .oRomAddr(addr0), .oNote(note0), .oPlaying(playing0), .oDone(done0)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_cyc   = 0;
  bit   use_zg  = 1'b0;
  exp_t q[$];
  int   sn[4];
  int   sb[4];

  task automatic push(input logic [7:0] n, input logic p, input logic d, input int a,
                      input int cnt);
    exp_t e;
    e.note = n; e.playing = p; e.done = d; e.addr = a[7:0];
    for (int i = 0; i < cnt; i++) q.push_back(e);
  endtask

  // Model of one playback from base: FETCH/LOAD, note, optional rest, hold during next fetch.
  task automatic push_song(input int base, input int n, input bit zg);
    int a;
    push(8'd0, 1'b1, 1'b0, base, 2);
    for (int i = 0; i < n; i++) begin
      a = base + i;
      push(sn[i][7:0], 1'b1, 1'b0, a, sb[i] * Tpb);
      if (!zg) push(8'd99, 1'b1, 1'b0, a, Gap);
      if (i == SlotLen - 1) begin
        push(8'd0, 1'b0, 1'b1, a, 1);
        push(8'd0, 1'b0, 1'b0, a, 1);
        return;
      end
      push(sn[i][7:0], 1'b1, 1'b0, a + 1, 2);
    end
    push(8'd0, 1'b0, 1'b1, base + n, 1);
    push(8'd0, 1'b0, 1'b0, base + n, 1);
  endtask

  task automatic cycle_check();
    exp_t e;
    logic [17:0] got;
    @(posedge clk);
    #1;
    n_cyc++;
    n_tests++;
    if (q.size() == 0) begin
      n_fail++;
      $error("FAIL underflow cyc%0d: got no expected entry, required one queued", n_cyc);
      return;
    end
    e = q.pop_front();
    got = use_zg ? {note0, playing0, done0, addr0} : {note, playing, done, addr};
    assert (got === e) else begin
      n_fail++;
      $error("FAIL cyc%0d: got note=%0d play=%0b done=%0b addr=%0d, want note=%0d play=%0b done=%0b addr=%0d",
             n_cyc, got[17:10], got[9], got[8], got[7:0], e.note, e.playing, e.done, e.addr);
    end
  endtask

  task automatic drain();
    while (q.size() != 0) cycle_check();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle_check();
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      rom[i]  = 12'h000;
      rom0[i] = 12'h000;
    end
    rom[0] = {8'd10, 4'd2};
    rom[1] = {8'd12, 4'd1};
    for (int i = 0; i < 4; i++) rom[4 + i] = {8'(20 + i), 4'd1};
    rom[8]  = {8'd55, 4'd3};
    rom0[0] = {8'd10, 4'd1};
    rom0[1] = {8'd99, 4'd1};
    rom0[2] = {8'd10, 4'd1};

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; start0 = 1'b0; stop0 = 1'b0; sel = 2'd0;
    #12 rst_n = 1'b1;
    #1;
    chk("reset_note", 32'(note), 32'd0);
    chk("reset_playing", 32'(playing), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_addr", 32'(addr), 32'd0);

    // Basic play of slot 0
    sn = '{10, 12, 0, 0}; sb = '{2, 1, 0, 0};
    push_song(0, 2, 1'b0);
    start = 1'b1; cycle_check(); start = 1'b0;
    drain();

    // Full slot 1 without end marker: reads 4..7 then stops
    sel = 2'd1;
    sn = '{20, 21, 22, 23}; sb = '{1, 1, 1, 1};
    push_song(4, 4, 1'b0);
    start = 1'b1; cycle_check(); start = 1'b0;
    drain();
    sel = 2'd0;

    // Abort during the second note, then replay from address 0
    push(8'd0, 1'b1, 1'b0, 0, 2);
    push(8'd10, 1'b1, 1'b0, 0, 8);
    push(8'd99, 1'b1, 1'b0, 0, 2);
    push(8'd10, 1'b1, 1'b0, 1, 2);
    push(8'd12, 1'b1, 1'b0, 1, 2);
    start = 1'b1; cycle_check(); start = 1'b0;
    drain();
    stop = 1'b1;
    push(8'd0, 1'b0, 1'b0, 1, 1);
    cycle_check();
    stop = 1'b0;
    push(8'd0, 1'b0, 1'b0, 1, 2);
    drain();
    sn = '{10, 12, 0, 0}; sb = '{2, 1, 0, 0};
    push_song(0, 2, 1'b0);
    start = 1'b1; cycle_check(); start = 1'b0;
    drain();

    // Start with stop in idle: stop wins
    start = 1'b1; stop = 1'b1;
    push(8'd0, 1'b0, 1'b0, 2, 3);
    drain();
    start = 1'b0; stop = 1'b0;

    // Start and song-select changes during playback are ignored
    push_song(0, 2, 1'b0);
    start = 1'b1; cycle_check(); start = 1'b0;
    run(6);
    start = 1'b1; sel = 2'd1;
    run(2);
    start = 1'b0;
    drain();
    sel = 2'd0;

    // Async reset during the rest gap
    push(8'd0, 1'b1, 1'b0, 0, 2);
    push(8'd10, 1'b1, 1'b0, 0, 8);
    push(8'd99, 1'b1, 1'b0, 0, 1);
    start = 1'b1; cycle_check(); start = 1'b0;
    drain();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_note", 32'(note), 32'd0);
    chk("async_rst_playing", 32'(playing), 32'd0);
    chk("async_rst_addr", 32'(addr), 32'd0);
    #3 rst_n = 1'b1;
    push(8'd0, 1'b0, 1'b0, 0, 2);
    drain();

    // Zero-gap instance
    use_zg = 1'b1;
    sn = '{10, 99, 10, 0}; sb = '{1, 1, 1, 0};
    push_song(0, 3, 1'b1);
    start0 = 1'b1; cycle_check(); start0 = 1'b0;
    drain();
    use_zg = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
